acc_sampler: RTL and testbench

ACC_SAMPLER -- requirements
Module: acc_sampler

---
 rtl/acc_sampler_pkg.sv | 16 +
 rtl/acc_fifo.sv | 54 +++++
 rtl/acc_sampler.sv | 91 +++++++++
 tb/tb_acc_sampler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_sampler_pkg.sv
// Shared accumulator-chain definitions: default widths and drop-counter helpers.
package acc_sampler_pkg;

  localparam int NB_DATA_DEF = 3;
  localparam int NB_DIV_DEF  = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int NB_DROP     = 8;

  localparam logic [NB_DROP-1:0] DROP_MAX = '1;

  // Saturating increment used by the dropped-sample counter.
  function automatic logic [NB_DROP-1:0] sat_inc(input logic [NB_DROP-1:0] value);
    return (value == DROP_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/acc_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers and exact occupancy.
module acc_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign o_level = wr_ptr - rd_ptr;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is fine then.
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);

  // Head is masked to zero while empty so stale storage never leaks out.
  assign o_rdata = o_empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage is not reset; the empty mask hides whatever it holds after reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  // Pointer advance; reset discards all contents by collapsing both pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/acc_sampler.sv
// Samples an accumulator value every i_div+1 enabled cycles into a small FIFO,
// tracking sticky overflow and the number of samples lost to a full FIFO.
module acc_sampler
  import acc_sampler_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int NB_DIV  = NB_DIV_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [2*NB_DATA-1:0]     i_data,
  input  logic                     i_overflow,
  input  logic                     i_enable,
  input  logic [NB_DIV-1:0]        i_div,
  input  logic                     i_clr_sticky,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [2*NB_DATA-1:0]     o_data,
  output logic                     o_ovf_flag,
  output logic                     o_sticky_ovf,
  output logic [NB_DROP-1:0]       o_drop_cnt,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int NB_WORD = 2*NB_DATA + 1;

  logic [NB_DIV-1:0]  div_cnt;
  logic               strobe;
  logic               pop;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [NB_WORD-1:0] head;

  // Using >= rather than == lets a lowered i_div take effect mid-count.
  assign strobe = i_enable && (div_cnt >= i_div);

  assign o_valid    = !fifo_empty;
  assign pop        = o_valid && i_ready;
  assign drop       = strobe && fifo_full && !pop;
  assign o_ovf_flag = head[NB_WORD-1];
  assign o_data     = head[NB_WORD-2:0];

  // Divider: idles at zero when disabled and restarts from zero on each strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt <= '0;
    end else if (!i_enable || strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Sticky overflow watches every enabled cycle; a new overflow beats a clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sticky_ovf <= 1'b0;
    end else if (i_enable && i_overflow) begin
      o_sticky_ovf <= 1'b1;
    end else if (i_clr_sticky) begin
      o_sticky_ovf <= 1'b0;
    end
  end

  // Dropped-sample counter saturates and is cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_drop_cnt <= sat_inc(o_drop_cnt);
    end
  end

  acc_fifo #(
    .WIDTH (NB_WORD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (strobe),
    .i_wdata ({i_overflow, i_data}),
    .i_pop   (pop),
    .o_rdata (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

endmodule

// File: tb/tb_acc_sampler.sv
// Scoreboard bench for acc_sampler: samples are queued as they are strobed and
// compared against the FIFO head whenever the bench pops it.
module tb_acc_sampler;
  import acc_sampler_pkg::*;

  localparam int NB_DATA = NB_DATA_DEF;
  localparam int NB_DIV  = NB_DIV_DEF;
  localparam int DEPTH   = DEPTH_DEF;
  localparam int NB_LVL  = $clog2(DEPTH) + 1;
  localparam int NB_WORD = 2*NB_DATA + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [2*NB_DATA-1:0]  data = '0;
  logic                  ovf = 1'b0;
  logic                  en = 1'b0;
  logic [NB_DIV-1:0]     div = '0;
  logic                  clr = 1'b0;
  logic                  ready = 1'b0;
  logic                  o_valid;
  logic [2*NB_DATA-1:0]  o_data;
  logic                  o_ovf_flag;
  logic                  o_sticky_ovf;
  logic [NB_DROP-1:0]    o_drop_cnt;
  logic [NB_LVL-1:0]     o_level;

  logic [NB_WORD-1:0] exp_q [$];
  logic [NB_WORD-1:0] exp_word;
  int                 model_drop = 0;
  int                 errors = 0;
  int                 checks = 0;

  acc_sampler #(
    .NB_DATA (NB_DATA),
    .DEPTH   (DEPTH),
    .NB_DIV  (NB_DIV)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (data),
    .i_overflow   (ovf),
    .i_enable     (en),
    .i_div        (div),
    .i_clr_sticky (clr),
    .i_ready      (ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_ovf_flag   (o_ovf_flag),
    .o_sticky_ovf (o_sticky_ovf),
    .o_drop_cnt   (o_drop_cnt),
    .o_level      (o_level)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Models a strobe against the scoreboard: queued if room, otherwise a drop.
  task automatic sb_strobe(input logic o, input logic [2*NB_DATA-1:0] d, input bit popping);
    if (exp_q.size() < DEPTH || popping) exp_q.push_back({o, d});
    else if (model_drop < 255) model_drop++;
  endtask

  function automatic logic [NB_WORD-1:0] sb_pop();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic do_reset();
    en = 0; ovf = 0; clr = 0; ready = 0; data = '0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    exp_q.delete();
    model_drop = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    checks++;
    if ({o_valid, o_data, o_ovf_flag, o_sticky_ovf, o_drop_cnt, o_level} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%0d f=%b s=%b drop=%0d lvl=%0d want all 0",
               o_valid, o_data, o_ovf_flag, o_sticky_ovf, o_drop_cnt, o_level);
    end
    do_reset();
  endtask

  task automatic test_ramp();
    div = 0; ready = 1;
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) begin
        checks++;
        if (o_valid !== 1'b1) begin
          errors++; $display("[TB] FAIL ramp_latency: got valid=%b want 1 (sample %0d)", o_valid, i-1);
        end
      end
      if (o_valid && ready) begin
        exp_word = sb_pop();
        checks++;
        if ({o_ovf_flag, o_data} !== exp_word) begin
          errors++; $display("[TB] FAIL ramp_data: got %h want %h", {o_ovf_flag, o_data}, exp_word);
        end
      end
      en = 1; data = 6'(i);
      sb_strobe(1'b0, data, 1'b1);
      @(negedge clk);
      checks++;
      if (o_level > 1) begin
        errors++; $display("[TB] FAIL ramp_level: got %0d want <=1", o_level);
      end
    end
    en = 0;
    exp_word = sb_pop();
    checks++;
    if (o_valid !== 1'b1 || {o_ovf_flag, o_data} !== exp_word) begin
      errors++; $display("[TB] FAIL ramp_last: got v=%b %h want v=1 %h", o_valid, {o_ovf_flag, o_data}, exp_word);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_ovf_flag !== 1'b0) begin
      errors++; $display("[TB] FAIL ramp_empty: got v=%b d=%0d want v=0 d=0", o_valid, o_data);
    end
  endtask

  task automatic test_divider();
    div = 3; ready = 1;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (o_valid !== (c > 0 && ((c-1) % 4) == 3)) begin
        errors++; $display("[TB] FAIL div_pulse: cycle %0d got valid=%b", c, o_valid);
      end
      if (o_valid && ready) begin
        exp_word = sb_pop();
        checks++;
        if ({o_ovf_flag, o_data} !== exp_word) begin
          errors++; $display("[TB] FAIL div_data: got %h want %h", {o_ovf_flag, o_data}, exp_word);
        end
      end
      en = 1; data = 6'(c);
      if ((c % 4) == 3) sb_strobe(1'b0, data, 1'b1);
      @(negedge clk);
    end
    en = 0;
    exp_word = sb_pop();
    checks++;
    if (o_valid !== 1'b1 || {o_ovf_flag, o_data} !== exp_word) begin
      errors++; $display("[TB] FAIL div_last: got v=%b %h want v=1 %h", o_valid, {o_ovf_flag, o_data}, exp_word);
    end
    @(negedge clk);
  endtask

  task automatic test_fill_drop();
    do_reset();
    div = 0; ready = 0;
    for (int i = 0; i < 7; i++) begin
      en = 1; data = 6'(10 + i);
      sb_strobe(1'b0, data, 1'b0);
      @(negedge clk);
    end
    en = 0;
    checks++;
    if (o_level !== NB_LVL'(DEPTH) || o_drop_cnt !== 8'(model_drop)) begin
      errors++; $display("[TB] FAIL fill_state: got lvl=%0d drop=%0d want lvl=%0d drop=%0d",
                         o_level, o_drop_cnt, DEPTH, model_drop);
    end
    checks++;
    if (o_valid !== 1'b1 || {o_ovf_flag, o_data} !== exp_q[0]) begin
      errors++; $display("[TB] FAIL fill_head: got %h want %h", {o_ovf_flag, o_data}, exp_q[0]);
    end
    ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_word = sb_pop();
      checks++;
      if (o_valid !== 1'b1 || {o_ovf_flag, o_data} !== exp_word) begin
        errors++; $display("[TB] FAIL drain_order: pop %0d got v=%b %h want %h", i, o_valid, {o_ovf_flag, o_data}, exp_word);
      end
      @(negedge clk);
    end
    checks++;
    if (o_valid !== 1'b0 || o_level !== '0) begin
      errors++; $display("[TB] FAIL drain_empty: got v=%b lvl=%0d want 0 0", o_valid, o_level);
    end
  endtask

  task automatic test_back_to_back();
    ready = 0; div = 0;
    for (int i = 0; i < DEPTH; i++) begin
      en = 1; data = 6'(20 + i);
      sb_strobe(1'b0, data, 1'b0);
      @(negedge clk);
    end
    ready = 1; data = 6'd24;
    exp_word = sb_pop();
    checks++;
    if ({o_ovf_flag, o_data} !== exp_word) begin
      errors++; $display("[TB] FAIL full_pop_head: got %h want %h", {o_ovf_flag, o_data}, exp_word);
    end
    sb_strobe(1'b0, data, 1'b1);
    @(negedge clk);
    en = 0;
    checks++;
    if (o_level !== NB_LVL'(DEPTH) || o_drop_cnt !== 8'(model_drop)) begin
      errors++; $display("[TB] FAIL full_push_pop: got lvl=%0d drop=%0d want lvl=%0d drop=%0d",
                         o_level, o_drop_cnt, DEPTH, model_drop);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_word = sb_pop();
      checks++;
      if (o_valid !== 1'b1 || {o_ovf_flag, o_data} !== exp_word) begin
        errors++; $display("[TB] FAIL b2b_order: pop %0d got v=%b %h want %h", i, o_valid, {o_ovf_flag, o_data}, exp_word);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sticky();
    div = 0; ready = 1;
    en = 1; ovf = 1; clr = 1; data = 6'd5;
    sb_strobe(1'b1, data, 1'b1);
    @(negedge clk);
    en = 0; ovf = 0; clr = 1;
    checks++;
    if (o_sticky_ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL sticky_set_wins: got %b want 1", o_sticky_ovf);
    end
    exp_word = sb_pop();
    checks++;
    if (o_valid !== 1'b1 || {o_ovf_flag, o_data} !== exp_word) begin
      errors++; $display("[TB] FAIL sticky_head: got v=%b %h want %h", o_valid, {o_ovf_flag, o_data}, exp_word);
    end
    @(negedge clk);
    clr = 0;
    checks++;
    if (o_sticky_ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL sticky_clear: got %b want 0", o_sticky_ovf);
    end
    div = 3; en = 1; ovf = 1;
    @(negedge clk);
    en = 0; ovf = 0;
    checks++;
    if (o_sticky_ovf !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL sticky_no_strobe: got s=%b v=%b want s=1 v=0", o_sticky_ovf, o_valid);
    end
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic test_drop_saturate();
    do_reset();
    div = 0; ready = 0;
    for (int i = 0; i < DEPTH + 260; i++) begin
      en = 1; data = 6'(i);
      sb_strobe(1'b0, data, 1'b0);
      @(negedge clk);
    end
    en = 0;
    checks++;
    if (o_drop_cnt !== 8'(model_drop) || o_level !== NB_LVL'(DEPTH)) begin
      errors++; $display("[TB] FAIL drop_saturate: got drop=%0d lvl=%0d want drop=%0d lvl=%0d",
                         o_drop_cnt, o_level, model_drop, DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    div = 0; ready = 0;
    for (int i = 0; i < 9; i++) begin
      en = 1; data = 6'(30 + i);
      sb_strobe(1'b0, data, 1'b0);
      @(negedge clk);
    end
    en = 0; ready = 1;
    exp_word = sb_pop();
    @(negedge clk);
    ready = 0;
    checks++;
    if (o_level !== NB_LVL'(3) || o_drop_cnt !== 8'd5) begin
      errors++; $display("[TB] FAIL pre_reset: got lvl=%0d drop=%0d want 3 5", o_level, o_drop_cnt);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({o_valid, o_data, o_ovf_flag, o_sticky_ovf, o_drop_cnt, o_level} !== '0) begin
      errors++; $display("[TB] FAIL async_reset: got v=%b d=%0d drop=%0d lvl=%0d want all 0",
                         o_valid, o_data, o_drop_cnt, o_level);
    end
    @(negedge clk);
    rst_n = 1;
    exp_q.delete();
    model_drop = 0;
    div = 2; ready = 1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL restart_early: cycle %0d got valid=%b want 0", c, o_valid);
      end
      en = 1; data = 6'(40 + c);
      if (c == 2) sb_strobe(1'b0, data, 1'b1);
      @(negedge clk);
    end
    en = 0;
    exp_word = sb_pop();
    checks++;
    if (o_valid !== 1'b1 || {o_ovf_flag, o_data} !== exp_word) begin
      errors++; $display("[TB] FAIL restart_sample: got v=%b %h want v=1 %h", o_valid, {o_ovf_flag, o_data}, exp_word);
    end
    @(negedge clk);
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    $display("[TB] starting acc_sampler bench");
    test_reset();
    test_ramp();
    test_divider();
    test_fill_drop();
    test_back_to_back();
    test_sticky();
    test_drop_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
